// File: rtl/vpu_wb_unit.sv
// VPU write-back unit: collects lane result beats into one SRAM line and writes it to the bank/row decoded from dst0.
// Optional feature macro VPU_WB_ALIGN_CHK_EN: sticky err_o when a pushed dst0 address has non-zero offset bits.
module vpu_wb_unit #(
    parameter int DST_FIFO_DEPTH  = 4,
    parameter int LANE_DATA_WIDTH = 256,
    parameter int BEATS_PER_LINE  = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      dst_valid_i,
    output logic                                      dst_ready_o,
    input  logic [31:0]                               dst_addr_i,
    input  logic                                      beat_valid_i,
    output logic                                      beat_ready_o,
    input  logic [LANE_DATA_WIDTH-1:0]                beat_data_i,
    output logic [3:0]                                sram_wren_o,
    output logic [9:0]                                sram_waddr_o,
    output logic [BEATS_PER_LINE*LANE_DATA_WIDTH-1:0] sram_wdata_o,
    output logic                                      wb_done_o,
    output logic [31:0]                               wb_addr_o,
    output logic                                      err_o
);

    localparam int SRAM_DATA_WIDTH     = BEATS_PER_LINE * LANE_DATA_WIDTH;
    localparam int SRAM_DATA_WIDTH_LG2 = $clog2(SRAM_DATA_WIDTH);
    localparam int SRAM_BANK_CNT_LG2   = 2;
    localparam int SRAM_BANK_DEPTH_LG2 = 10;
    localparam int BANK_LO             = SRAM_DATA_WIDTH_LG2;
    localparam int BANK_HI             = BANK_LO + SRAM_BANK_CNT_LG2 - 1;
    localparam int ROW_LO              = BANK_HI + 1;
    localparam int ROW_HI              = ROW_LO + SRAM_BANK_DEPTH_LG2 - 1;
    localparam int PTR_W               = $clog2(DST_FIFO_DEPTH);
    localparam int BCNT_W              = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;

    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(DST_FIFO_DEPTH);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE
    } state_e;

    state_e                     state_q;
    logic [31:0]                fifo_q [DST_FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [PTR_W:0]             cnt_q;
    logic [PTR_W:0]             cnt_d;
    logic                       dst_ready_q;
    logic                       beat_ready_q;
    logic [BCNT_W-1:0]          beat_cnt_q;
    logic [SRAM_DATA_WIDTH-1:0] line_q;
    logic [SRAM_DATA_WIDTH-1:0] line_d;
    logic [3:0]                 wren_q;
    logic [9:0]                 waddr_q;
    logic [SRAM_DATA_WIDTH-1:0] wdata_q;
    logic                       done_q;
    logic [31:0]                wb_addr_q;
    logic [31:0]                head_addr;
    logic                       push;
    logic                       pop;
    logic                       beat_acc;

    assign head_addr = fifo_q[rd_ptr_q];
    assign push      = dst_valid_i & dst_ready_q;
    assign pop       = (state_q == WRITE);
    assign beat_acc  = beat_valid_i & beat_ready_q;

    assign cnt_d = cnt_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    always_comb begin
        line_d = line_q;
        for (int k = 0; k < BEATS_PER_LINE; k++) begin
            if (beat_cnt_q == BCNT_W'(k)) begin
                line_d[k*LANE_DATA_WIDTH +: LANE_DATA_WIDTH] = beat_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= dst_addr_i;
        end
    end

    // Ready is registered from the next count, so it reads as !full of the stored count and stays low in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            dst_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q       <= cnt_d;
            dst_ready_q <= (cnt_d != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_ready_q <= 1'b0;
            beat_cnt_q   <= '0;
            line_q       <= '0;
            wren_q       <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            wb_addr_q    <= '0;
        end else begin
            wren_q <= '0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cnt_q != '0) begin
                        state_q      <= COLLECT;
                        beat_ready_q <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (beat_acc) begin
                        line_q <= line_d;
                        if (beat_cnt_q == LAST_BEAT) begin
                            state_q      <= WRITE;
                            beat_ready_q <= 1'b0;
                            wren_q       <= 4'b0001 << head_addr[BANK_HI:BANK_LO];
                            waddr_q      <= head_addr[ROW_HI:ROW_LO];
                            wdata_q      <= line_d;
                            done_q       <= 1'b1;
                            wb_addr_q    <= head_addr;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    beat_cnt_q   <= '0;
                    state_q      <= (cnt_d != '0) ? COLLECT : IDLE;
                    beat_ready_q <= (cnt_d != '0);
                end
                default: begin
                    state_q      <= IDLE;
                    beat_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign dst_ready_o  = dst_ready_q;
    assign beat_ready_o = beat_ready_q;
    assign sram_wren_o  = wren_q;
    assign sram_waddr_o = waddr_q;
    assign sram_wdata_o = wdata_q;
    assign wb_done_o    = done_q;
    assign wb_addr_o    = wb_addr_q;

`ifdef VPU_WB_ALIGN_CHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (push && (dst_addr_i[SRAM_DATA_WIDTH_LG2-1:0] != '0)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vpu_wb_unit.sv
// Self-checking bench for vpu_wb_unit: directed test-plan steps plus random traffic against a queue-based model.
// Honours VPU_WB_ALIGN_CHK_EN for the expected err_o behaviour.
module tb_vpu_wb_unit;

    localparam int LW = 256;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dst_valid_i;
    logic          dst_ready_o;
    logic [31:0]   dst_addr_i;
    logic          beat_valid_i;
    logic          beat_ready_o;
    logic [LW-1:0] beat_data_i;
    logic [3:0]    sram_wren_o;
    logic [9:0]    sram_waddr_o;
    logic [DW-1:0] sram_wdata_o;
    logic          wb_done_o;
    logic [31:0]   wb_addr_o;
    logic          err_o;

    always #5 clk = ~clk;

    vpu_wb_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dst_valid_i  (dst_valid_i),
        .dst_ready_o  (dst_ready_o),
        .dst_addr_i   (dst_addr_i),
        .beat_valid_i (beat_valid_i),
        .beat_ready_o (beat_ready_o),
        .beat_data_i  (beat_data_i),
        .sram_wren_o  (sram_wren_o),
        .sram_waddr_o (sram_waddr_o),
        .sram_wdata_o (sram_wdata_o),
        .wb_done_o    (wb_done_o),
        .wb_addr_o    (wb_addr_o),
        .err_o        (err_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending dst0 addresses, the line being gathered, and the last issued write.
    logic [31:0]   mQ[$];
    bit            mOpen;
    bit            mWriting;
    bit            mReadyDst;
    bit            mErr;
    int            mBeats;
    logic [DW-1:0] mLine;
    logic [DW-1:0] mWdata;
    logic [9:0]    mWaddr;
    logic [3:0]    mWren;
    logic [31:0]   mWbAddr;

    task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeoutFail(input string tag);
        total++;
        bad++;
        $error("[TB] FAIL %s: observed=no handshake expected=handshake within 50 cycles", tag);
    endtask

    task automatic modelReset();
        mQ.delete();
        mOpen     = 1'b0;
        mWriting  = 1'b0;
        mReadyDst = 1'b0;
        mErr      = 1'b0;
        mBeats    = 0;
        mLine     = '0;
        mWdata    = '0;
        mWaddr    = '0;
        mWren     = '0;
        mWbAddr   = '0;
    endtask

    task automatic modelAdvance();
        bit push;
        bit accept;
        bit hadEntry;
        if (!rst_n) begin
            modelReset();
        end else begin
            push     = dst_valid_i && mReadyDst;
            accept   = beat_valid_i && mOpen;
            hadEntry = (mQ.size() > 0);
            if (mWriting) begin
                void'(mQ.pop_front());
                mWriting = 1'b0;
                mBeats   = 0;
                if (push) mQ.push_back(dst_addr_i);
                mOpen = (mQ.size() > 0);
            end else begin
                if (accept) begin
                    mLine[mBeats*LW +: LW] = beat_data_i;
                    mBeats++;
                    if (mBeats == 2) begin
                        mOpen    = 1'b0;
                        mWriting = 1'b1;
                        mWdata   = mLine;
                        mWren    = 4'(1 << ((mQ[0] / 512) % 4));
                        mWaddr   = 10'((mQ[0] / 2048) % 1024);
                        mWbAddr  = mQ[0];
                    end
                end else if (!mOpen && hadEntry) begin
                    mOpen = 1'b1;
                end
                if (push) mQ.push_back(dst_addr_i);
            end
`ifdef VPU_WB_ALIGN_CHK_EN
            if (push && (dst_addr_i % 512) != 0) mErr = 1'b1;
`endif
            mReadyDst = (mQ.size() < 4);
        end
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, "/dst_ready"}, dst_ready_o, mReadyDst);
        cmp({tag, "/beat_ready"}, beat_ready_o, mOpen);
        cmp({tag, "/wren"}, sram_wren_o, mWriting ? mWren : 4'b0000);
        cmp({tag, "/done"}, wb_done_o, mWriting);
        cmp({tag, "/waddr"}, sram_waddr_o, mWaddr);
        cmp({tag, "/wdata"}, sram_wdata_o, mWdata);
        cmp({tag, "/err"}, err_o, mErr);
        if (mWriting) cmp({tag, "/wb_addr"}, wb_addr_o, mWbAddr);
    endtask

    task automatic applyStimulus(input logic rst, input logic dv, input logic [31:0] a,
                                 input logic bv, input logic [LW-1:0] d);
        rst_n        = rst;
        dst_valid_i  = dv;
        dst_addr_i   = a;
        beat_valid_i = bv;
        beat_data_i  = d;
    endtask

    task automatic step(input string tag);
        checkOutput(tag);
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, beat_data_i);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic pushAddr(input logic [31:0] a, input string tag);
        int n = 0;
        applyStimulus(rst_n, 1'b1, a, beat_valid_i, beat_data_i);
        while (!mReadyDst && n < 50) begin
            step(tag);
            n++;
        end
        if (!mReadyDst) timeoutFail(tag);
        else step(tag);
        applyStimulus(rst_n, 1'b0, a, beat_valid_i, beat_data_i);
    endtask

    task automatic sendBeat(input logic [LW-1:0] d, input string tag);
        int n = 0;
        applyStimulus(rst_n, dst_valid_i, dst_addr_i, 1'b1, d);
        while (!mOpen && n < 50) begin
            step(tag);
            n++;
        end
        if (!mOpen) timeoutFail(tag);
        else step(tag);
        applyStimulus(rst_n, dst_valid_i, dst_addr_i, 1'b0, d);
    endtask

    function automatic logic [LW-1:0] fill(input logic [31:0] w);
        return {8{w}};
    endfunction

    function automatic logic [LW-1:0] randBeat();
        logic [LW-1:0] d;
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [31:0] fullAddrs[5];
        logic [LW-1:0] pendData;
        bit pending;
        int n;

        fullAddrs[0] = 32'h0000_0000;
        fullAddrs[1] = 32'h0000_1200;
        fullAddrs[2] = 32'h0012_3400;
        fullAddrs[3] = 32'h0000_0600;
        fullAddrs[4] = 32'h0004_0A00;

        // Reset
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
        modelReset();
        @(posedge clk);
        #1;
        step("reset");
        step("reset");
        cmp("reset_dst_ready_low", dst_ready_o, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        step("post_reset");
        cmp("post_reset_dst_ready_high", dst_ready_o, 1'b1);

        // Basic write
        pushAddr(32'h0000_0A00, "basic");
        sendBeat(fill(32'h1111_1111), "basic");
        sendBeat(fill(32'h2222_2222), "basic");
        cmp("basic_wren", sram_wren_o, 4'b0010);
        cmp("basic_waddr", sram_waddr_o, 10'd1);
        cmp("basic_wdata", sram_wdata_o, {fill(32'h2222_2222), fill(32'h1111_1111)});
        cmp("basic_done", wb_done_o, 1'b1);
        cmp("basic_wb_addr", wb_addr_o, 32'h0000_0A00);
        idle(2, "basic_tail");
        cmp("basic_wren_cleared", sram_wren_o, 4'b0000);

        // Decode extremes
        pushAddr(32'h001F_F800, "decode_hi_row");
        sendBeat(fill(32'hA5A5_0001), "decode_hi_row");
        sendBeat(fill(32'h5A5A_0002), "decode_hi_row");
        cmp("decode_hi_row_wren", sram_wren_o, 4'b0001);
        cmp("decode_hi_row_waddr", sram_waddr_o, 10'd1023);
        pushAddr(32'hFFE0_0600, "decode_tag");
        sendBeat(fill(32'h0BAD_F00D), "decode_tag");
        sendBeat(fill(32'hFEED_BEEF), "decode_tag");
        cmp("decode_tag_wren", sram_wren_o, 4'b1000);
        cmp("decode_tag_waddr", sram_waddr_o, 10'd0);
        idle(2, "decode_tail");

        // FIFO full, held fifth push, in-order drain
        for (int i = 0; i < 4; i++) pushAddr(fullAddrs[i], "fifo_fill");
        cmp("fifo_full_ready_low", dst_ready_o, 1'b0);
        applyStimulus(1'b1, 1'b1, fullAddrs[4], 1'b0, beat_data_i);
        step("fifo_held");
        step("fifo_held");
        sendBeat(fill(32'h3000_0000), "fifo_line0");
        sendBeat(fill(32'h3000_0001), "fifo_line0");
        cmp("fifo_line0_wb_addr", wb_addr_o, fullAddrs[0]);
        cmp("fifo_write_ready_still_low", dst_ready_o, 1'b0);
        step("fifo_pop");
        cmp("fifo_ready_after_pop", dst_ready_o, 1'b1);
        step("fifo_fifth_push");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, beat_data_i);
        for (int i = 1; i < 5; i++) begin
            sendBeat(fill(32'h3100_0000 + i), "fifo_drain");
            sendBeat(fill(32'h3200_0000 + i), "fifo_drain");
            cmp("fifo_drain_wb_addr", wb_addr_o, fullAddrs[i]);
        end
        idle(2, "fifo_tail");

        // Back-pressure with empty FIFO
        applyStimulus(1'b1, 1'b0, '0, 1'b1, fill(32'h4444_4444));
        step("bp_empty");
        step("bp_empty");
        step("bp_empty");
        cmp("bp_beat_ready_low", beat_ready_o, 1'b0);
        pushAddr(32'h0000_2200, "bp_push");
        cmp("bp_idle_cycle_ready_low", beat_ready_o, 1'b0);
        sendBeat(fill(32'h4444_4444), "bp_beat");
        sendBeat(fill(32'h5555_5555), "bp_beat");
        cmp("bp_wdata", sram_wdata_o, {fill(32'h5555_5555), fill(32'h4444_4444)});
        idle(2, "bp_tail");

        // Reset mid-line
        pushAddr(32'h0000_4000, "rst_mid");
        sendBeat(fill(32'h6666_6666), "rst_mid");
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
        step("rst_mid_pulse");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        cmp("rst_mid_wren", sram_wren_o, 4'b0000);
        cmp("rst_mid_wdata", sram_wdata_o, '0);
        cmp("rst_mid_done", wb_done_o, 1'b0);
        step("rst_mid_recover");
        step("rst_mid_recover");
        pushAddr(32'h0000_0200, "rst_new");
        sendBeat(fill(32'h7777_7777), "rst_new");
        sendBeat(fill(32'h8888_8888), "rst_new");
        cmp("rst_new_wdata", sram_wdata_o, {fill(32'h8888_8888), fill(32'h7777_7777)});
        cmp("rst_new_wren", sram_wren_o, 4'b0010);
        idle(2, "rst_tail");

        // Alignment check
        pushAddr(32'h0000_0A04, "align");
`ifdef VPU_WB_ALIGN_CHK_EN
        cmp("align_err_set", err_o, 1'b1);
`else
        cmp("align_err_off", err_o, 1'b0);
`endif
        sendBeat(fill(32'h9999_9999), "align");
        sendBeat(fill(32'hAAAA_AAAA), "align");
        cmp("align_wren", sram_wren_o, 4'b0010);
        cmp("align_waddr", sram_waddr_o, 10'd1);
        idle(3, "align_tail");

        // Random traffic
        pending = 1'b0;
        pendData = '0;
        for (int c = 0; c < 400; c++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[8:0] = '0;
            if (!pending && $urandom_range(0, 1) == 1) begin
                pendData = randBeat();
                pending  = 1'b1;
            end
            applyStimulus(1'b1, ($urandom_range(0, 2) == 0), a, pending, pendData);
            if (pending && mOpen) pending = 1'b0;
            step("random");
        end

        // Drain whatever is still pending
        n = 0;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, beat_data_i);
        while ((mQ.size() > 0 || mWriting) && n < 200) begin
            if (!pending) begin
                pendData = randBeat();
                pending  = 1'b1;
            end
            applyStimulus(1'b1, 1'b0, '0, 1'b1, pendData);
            if (mOpen) pending = 1'b0;
            step("drain");
            n++;
        end
        if (mQ.size() > 0 || mWriting) timeoutFail("drain");
        idle(2, "final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vpu_wb_unit.md
Name: vpu_wb_unit

Overview:
- Write-back end of the VPU SRAM path: collects lane result beats from the vector lanes, assembles them into one 512-bit SRAM line, and writes that line to the bank and row decoded from the instruction's dst0 address.
- Sits between the vlane array and the SRAM write port, which is the single DST_OPERAND_CNT port.
- Mirrors the operand-read path: the decode uses the same TAG | BANK_ID | DIM_OFFSET mapping as the read side.

Parameters:
- DST_FIFO_DEPTH, 4: number of pending dst0 addresses (power of two, ≥2).
- LANE_DATA_WIDTH, VLANE_CNT*ELEM_WIDTH (256): width of one result beat.
- BEATS_PER_LINE, EXEC_CNT (2): beats per SRAM line; SRAM_DATA_WIDTH = BEATS_PER_LINE*LANE_DATA_WIDTH.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- dst_valid_i  input  1  dst0 address request valid
- dst_ready_o  output  1  dst FIFO not full
- dst_addr_i  input  OPERAND_ADDR_WIDTH(32)  dst0 operand address
- beat_valid_i  input  1  lane result beat valid
- beat_ready_o  output  1  beat accepted this cycle when valid&ready
- beat_data_i  input  LANE_DATA_WIDTH  result beat, lanes packed with lane0 at the LSB
- sram_wren_o  output  SRAM_BANK_CNT(4)  one-hot bank write enable
- sram_waddr_o  output  SRAM_BANK_DEPTH_LG2(10)  bank row address
- sram_wdata_o  output  SRAM_DATA_WIDTH(512)  line data
- wb_done_o  output  1  one-cycle pulse when the line write is issued
- wb_addr_o  output  32  dst0 address of the completed line (valid with wb_done_o)
- err_o  output  1  sticky misalignment flag (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; synchronous active-low reset rst_n sampled on the rising edge.
- Reset values:
  - All outputs 0, except dst_ready_o, which is 1 one cycle after reset deasserts.
  - FIFO empty, beat counter 0, partial line cleared, FSM in IDLE.
- Address decode, at FIFO head:
  - bank = addr[SRAM_BANK_CNT_LG2+SRAM_DATA_WIDTH_LG2-1 : SRAM_DATA_WIDTH_LG2], i.e. [10:9].
  - row = addr[SRAM_SIZE_LG2-1 : SRAM_BANK_CNT_LG2+SRAM_DATA_WIDTH_LG2], i.e. [20:11].
  - Tag bits [31:21] are ignored. DIM_OFFSET bits [8:0] are ignored for addressing.
- dst FIFO:
  - Push on dst_valid_i & dst_ready_o.
  - dst_ready_o = !full, computed from the registered count; there is no same-cycle pop bypass.
  - Simultaneous push and pop leave the count unchanged.
- FSM:
  - IDLE: FIFO empty; beat_ready_o=0. Go to COLLECT when the FIFO is non-empty.
  - COLLECT: beat_ready_o=1.
    - Each accepted beat k is written into line[k*LANE_DATA_WIDTH +: LANE_DATA_WIDTH]; beat_cnt increments.
    - When beat k = BEATS_PER_LINE-1 is accepted, go to WRITE.
  - WRITE: lasts exactly one cycle.
    - sram_wren_o = 1<<bank, with sram_waddr_o=row and sram_wdata_o=line, all registered.
    - wb_done_o=1 and wb_addr_o=head address.
    - Pop the FIFO and clear beat_cnt. beat_ready_o=0.
    - Next state is COLLECT if the FIFO still holds an entry after the pop (including one pushed this cycle), else IDLE.
- Latency: last beat accepted in cycle N → sram_wren_o and wb_done_o asserted in cycle N+1.
- Throughput: one line per BEATS_PER_LINE+1 cycles.
- Outside WRITE: sram_wren_o=0 and wb_done_o=0. sram_waddr_o and sram_wdata_o hold their last values.
- Beats presented while beat_ready_o=0 are not consumed; the producer holds beat_data_i stable.
- Reset mid-line: the partial line and pending addresses are discarded, with no write issued.
- Back-to-back: the next address's first beat may be accepted in the cycle after WRITE.

Optional Feature:
- Macro: VPU_WB_ALIGN_CHK_EN.
- Defined:
  - At FIFO push, if dst_addr_i[SRAM_DATA_WIDTH_LG2-1:0] != 0, err_o is set in the following cycle.
  - err_o stays set until reset.
  - The write still proceeds with the offset bits ignored.
- Undefined: err_o is tied to 0 and no check logic is generated.

Test Plan:
- Basic write:
  - Stimulus: push dst 0x0000_0A00; beats 0x1111..11 then 0x2222..22.
  - Required: sram_wren_o=4'b0010, waddr=1, wdata={0x2222..,0x1111..}, wb_done_o one cycle after the last beat, wb_addr_o=0x0000_0A00.
- Decode extremes:
  - dst 0x001F_F800 → bank0 (wren=4'b0001), waddr=1023.
  - dst 0xFFE0_0600 → wren=4'b1000, waddr=0 (tag ignored).
- FIFO full:
  - Stimulus: push 4 addresses with no beats.
  - Required: dst_ready_o=0 after the 4th push; a 5th push is held. After 2 beats and the write, dst_ready_o=1 the next cycle. 4 lines then drain in order with wb_addr_o matching push order.
- Back-pressure:
  - Stimulus: beats offered with the FIFO empty.
  - Required: beat_ready_o=0 and no write. Then push an address → beats accepted starting the cycle after the FSM enters COLLECT.
- Reset mid-line:
  - Stimulus: accept 1 beat, then pulse rst_n=0 for 1 cycle.
  - Required: no sram_wren_o pulse, all outputs 0. A subsequent address plus 2 beats produces a line containing only the new beats.
- Alignment check (VPU_WB_ALIGN_CHK_EN):
  - Stimulus: push 0x0000_0A04.
  - Required: err_o=1 from the next cycle and sticky; the write goes to bank1, waddr 1.
  - Without the macro, err_o stays 0.
